// File: rtl/edit_sequencer_pkg.sv
// Shared codes for the edit sequencer: edit targets, mode codes, boton_ed bits,
// button slot indices and the cursor wrap helpers.
package edit_pkg;

    localparam logic [1:0] ED_NONE  = 2'd0;
    localparam logic [1:0] ED_TIMER = 2'd1;
    localparam logic [1:0] ED_FECHA = 2'd2;
    localparam logic [1:0] ED_HORA  = 2'd3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_EDIT  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;

    localparam int BE_UP    = 0;
    localparam int BE_DOWN  = 1;
    localparam int BE_LEFT  = 2;
    localparam int BE_RIGHT = 3;

    localparam int NUM_BTN    = 9;
    localparam int BTN_HORA   = 0;
    localparam int BTN_FECHA  = 1;
    localparam int BTN_TIMER  = 2;
    localparam int BTN_IZQ    = 3;
    localparam int BTN_DER    = 4;
    localparam int BTN_ARRIBA = 5;
    localparam int BTN_ABAJO  = 6;
    localparam int BTN_OK     = 7;
    localparam int BTN_CANCEL = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EDIT,
        S_WRITE_SETTLE,
        S_WRITE_REQ
    } fsm_t;

    // Cursor positions run 1..3; 0 means no field selected.
    function automatic logic [1:0] pos_inc(input logic [1:0] p);
        return (p == 2'd3) ? 2'd1 : p + 2'd1;
    endfunction

    function automatic logic [1:0] pos_dec(input logic [1:0] p);
        return (p == 2'd1) ? 2'd3 : p - 2'd1;
    endfunction

endpackage

// File: rtl/edit_sequencer_btn_debounce.sv
// One push-button front end: 2-flop synchronizer, stability counter and a
// single-cycle pulse on the rising edge of the accepted level.
module btn_debounce #(
    parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    logic        sync1_reg, sync2_reg;
    logic        level_reg, level_d_reg;
    logic [15:0] cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg   <= 1'b0;
            sync2_reg   <= 1'b0;
            level_reg   <= 1'b0;
            level_d_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            sync1_reg   <= raw;
            sync2_reg   <= sync1_reg;
            level_d_reg <= level_reg;
            // Any glitch back to the accepted level restarts the stability count.
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == DEB_CYCLES - 16'd1) begin
                level_reg <= sync2_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 16'd1;
            end
        end
    end

    assign pulse = level_reg & ~level_d_reg;

endmodule

// File: rtl/edit_sequencer.sv
// Button-driven edit controller: selects the edit target, moves the field
// cursor, emits up/down pulses and hands committed edits to the RTC writer.
module edit_sequencer
    import edit_pkg::*;
#(
    parameter int unsigned      CW             = 32,
    parameter logic [15:0]      DEB_CYCLES     = 16'd50000,
    parameter logic [CW-1:0]    TIMEOUT_CYCLES = 32'd500000000,
    parameter logic [15:0]      ACK_CYCLES     = 16'd1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_hora,
    input  logic       btn_fecha,
    input  logic       btn_timer,
    input  logic       btn_izq,
    input  logic       btn_der,
    input  logic       btn_arriba,
    input  logic       btn_abajo,
    input  logic       btn_ok,
    input  logic       btn_cancel,
    input  logic       wr_ack,
    output logic [1:0] FSMedit,
    output logic [1:0] FSMpos,
    output logic [3:0] boton_ed,
    output logic [2:0] state,
    output logic       wr_req,
    output logic [1:0] wr_sel,
    output logic       err
);

    logic [NUM_BTN-1:0] raw_btn;
    logic [NUM_BTN-1:0] p;

    assign raw_btn = {btn_cancel, btn_ok, btn_abajo, btn_arriba, btn_der,
                      btn_izq, btn_timer, btn_fecha, btn_hora};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_deb
            btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
                .clk   (clk),
                .reset (reset),
                .raw   (raw_btn[gi]),
                .pulse (p[gi])
            );
        end
    endgenerate

    fsm_t          fsm_reg, fsm_next;
    logic [1:0]    edit_reg, edit_next;
    logic [1:0]    pos_reg, pos_next;
    logic [3:0]    bed_reg, bed_next;
    logic [2:0]    state_reg, state_next;
    logic          wr_req_reg, wr_req_next;
    logic [1:0]    wr_sel_reg, wr_sel_next;
    logic          err_reg, err_next;
    logic [CW-1:0] tmo_reg, tmo_next;
    logic [15:0]   ack_reg, ack_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_reg    <= S_IDLE;
            edit_reg   <= ED_NONE;
            pos_reg    <= 2'd0;
            bed_reg    <= 4'd0;
            state_reg  <= ST_IDLE;
            wr_req_reg <= 1'b0;
            wr_sel_reg <= 2'd0;
            err_reg    <= 1'b0;
            tmo_reg    <= '0;
            ack_reg    <= '0;
        end else begin
            fsm_reg    <= fsm_next;
            edit_reg   <= edit_next;
            pos_reg    <= pos_next;
            bed_reg    <= bed_next;
            state_reg  <= state_next;
            wr_req_reg <= wr_req_next;
            wr_sel_reg <= wr_sel_next;
            err_reg    <= err_next;
            tmo_reg    <= tmo_next;
            ack_reg    <= ack_next;
        end
    end

    always_comb begin
        fsm_next    = fsm_reg;
        edit_next   = edit_reg;
        pos_next    = pos_reg;
        bed_next    = 4'd0;
        wr_req_next = wr_req_reg;
        wr_sel_next = wr_sel_reg;
        err_next    = 1'b0;
        tmo_next    = tmo_reg;
        ack_next    = ack_reg;
        state_next  = ST_IDLE;

        case (fsm_reg)
            S_IDLE: begin
                edit_next   = ED_NONE;
                pos_next    = 2'd0;
                wr_req_next = 1'b0;
                wr_sel_next = 2'd0;
                if (p[BTN_HORA] || p[BTN_FECHA] || p[BTN_TIMER]) begin
                    fsm_next  = S_EDIT;
                    pos_next  = 2'd1;
                    tmo_next  = '0;
                    edit_next = p[BTN_HORA]  ? ED_HORA  :
                                p[BTN_FECHA] ? ED_FECHA : ED_TIMER;
                end
            end
            S_EDIT: begin
                if (p[BTN_CANCEL] || tmo_reg == TIMEOUT_CYCLES - 1'b1) begin
                    fsm_next  = S_IDLE;
                    edit_next = ED_NONE;
                    pos_next  = 2'd0;
                end else if (p[BTN_OK]) begin
                    fsm_next = S_WRITE_SETTLE;
                end else begin
                    // Opposing pulses in the same cycle cancel each other.
                    if (p[BTN_IZQ] ^ p[BTN_DER]) begin
                        if (p[BTN_DER]) begin
                            pos_next           = pos_inc(pos_reg);
                            bed_next[BE_RIGHT] = 1'b1;
                        end else begin
                            pos_next          = pos_dec(pos_reg);
                            bed_next[BE_LEFT] = 1'b1;
                        end
                    end
                    if (p[BTN_ARRIBA] ^ p[BTN_ABAJO]) begin
                        bed_next[BE_UP]   = p[BTN_ARRIBA];
                        bed_next[BE_DOWN] = p[BTN_ABAJO];
                    end
                    if (p[BTN_IZQ] || p[BTN_DER] || p[BTN_ARRIBA] || p[BTN_ABAJO])
                        tmo_next = '0;
                    else
                        tmo_next = tmo_reg + 1'b1;
                end
            end
            S_WRITE_SETTLE: begin
                fsm_next    = S_WRITE_REQ;
                wr_req_next = 1'b1;
                wr_sel_next = edit_reg;
                ack_next    = '0;
            end
            S_WRITE_REQ: begin
                if (wr_ack || ack_reg == ACK_CYCLES - 16'd1) begin
                    fsm_next    = S_IDLE;
                    err_next    = ~wr_ack;
                    wr_req_next = 1'b0;
                    wr_sel_next = 2'd0;
                    edit_next   = ED_NONE;
                    pos_next    = 2'd0;
                end else begin
                    ack_next = ack_reg + 16'd1;
                end
            end
            default: fsm_next = S_IDLE;
        endcase

        case (fsm_next)
            S_EDIT:                      state_next = ST_EDIT;
            S_WRITE_SETTLE, S_WRITE_REQ: state_next = ST_WRITE;
            default:                     state_next = ST_IDLE;
        endcase
    end

    assign FSMedit  = edit_reg;
    assign FSMpos   = pos_reg;
    assign boton_ed = bed_reg;
    assign state    = state_reg;
    assign wr_req   = wr_req_reg;
    assign wr_sel   = wr_sel_reg;
    assign err      = err_reg;

endmodule
